// File: rtl/soc1_cpu_debug_action_scheduler.sv
// Debug action scheduler: queues take_action_* strobes with their jdo payloads
// and issues them one at a time to the OCI command port, waiting on the CPU monitor for ocimem ops.
module soc1_cpu_debug_action_scheduler #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         take_action_ocimem_a,
    input  logic                         take_action_ocimem_b,
    input  logic                         take_action_break_a,
    input  logic                         take_action_break_b,
    input  logic                         take_action_break_c,
    input  logic                         take_action_tracectrl,
    input  logic [37:0]                  jdo,
    input  logic                         cmd_ready,
    input  logic                         monitor_ready,
    input  logic                         monitor_error,
    input  logic                         clr_status,
    output logic                         cmd_valid,
    output logic [2:0]                   cmd_op,
    output logic [37:0]                  cmd_data,
    output logic                         cmd_done,
    output logic                         cmd_done_err,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         sticky_overflow,
    output logic                         sticky_collision,
    output logic                         sticky_timeout,
    output logic                         sticky_mon_error
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_MON = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [37:0] data;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       cmd_op_q, cmd_op_d;
    logic [37:0]      cmd_data_q, cmd_data_d;
    logic             cmd_done_q, cmd_done_d;
    logic             cmd_done_err_q, cmd_done_err_d;
    logic             busy_q, busy_d;
    logic             sticky_overflow_q, sticky_overflow_d;
    logic             sticky_collision_q, sticky_collision_d;
    logic             sticky_timeout_q, sticky_timeout_d;
    logic             sticky_mon_error_q, sticky_mon_error_d;

    logic [5:0]       strobe_c;
    logic [2:0]       win_op_c;
    logic             any_strobe_c;
    logic             collision_c;
    logic             fifo_full_c;
    logic             pop_c;
    logic             push_c;
    logic             overflow_c;
    logic             handshake_c;
    logic             mon_err_c;
    logic             mon_rdy_c;
    logic             timeout_c;

    assign strobe_c = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                       take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

    // Lowest-numbered strobe wins; scanning downward lets it overwrite the others.
    always_comb begin
        win_op_c = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (strobe_c[i]) begin
                win_op_c = 3'(i);
            end
        end
    end

    assign any_strobe_c = |strobe_c;
    assign collision_c  = |(strobe_c & (strobe_c - 6'd1));
    assign fifo_full_c  = (count_q == LW'(DEPTH));
    assign pop_c        = (state_q == ST_IDLE) && (count_q != '0);
    assign push_c       = any_strobe_c && (!fifo_full_c || pop_c);
    assign overflow_c   = any_strobe_c && fifo_full_c && !pop_c;
    assign handshake_c  = (state_q == ST_ISSUE) && cmd_valid_q && cmd_ready;
    assign mon_err_c    = (state_q == ST_WAIT_MON) && monitor_error;
    assign mon_rdy_c    = (state_q == ST_WAIT_MON) && monitor_ready && !monitor_error;
    assign timeout_c    = (state_q == ST_WAIT_MON) && !monitor_ready && !monitor_error
                          && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Command FIFO bookkeeping
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = '{op: win_op_c, data: jdo};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + LW'(push_c) - LW'(pop_c);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake_c) begin
                    state_d = (cmd_op_q < 3'd2) ? ST_WAIT_MON : ST_IDLE;
                end
            end
            ST_WAIT_MON: begin
                if (mon_err_c || mon_rdy_c || timeout_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cmd_valid_d    = (state_q == ST_ISSUE) && !handshake_c;
        cmd_op_d       = cmd_op_q;
        cmd_data_d     = cmd_data_q;
        if (pop_c) begin
            cmd_op_d   = mem_q[rd_ptr_q].op;
            cmd_data_d = mem_q[rd_ptr_q].data;
        end
        cmd_done_d     = (handshake_c && (cmd_op_q >= 3'd2)) || mon_err_c || mon_rdy_c || timeout_c;
        cmd_done_err_d = mon_err_c || timeout_c;
        busy_d         = (state_d != ST_IDLE) || (count_d != '0);
        tmo_cnt_d      = ((state_q == ST_WAIT_MON) && (state_d == ST_WAIT_MON))
                         ? tmo_cnt_q + TW'(1) : '0;
        // Setting a sticky wins over a simultaneous clear
        sticky_overflow_d  = overflow_c  || (sticky_overflow_q  && !clr_status);
        sticky_collision_d = collision_c || (sticky_collision_q && !clr_status);
        sticky_timeout_d   = timeout_c   || (sticky_timeout_q   && !clr_status);
        sticky_mon_error_d = mon_err_c   || (sticky_mon_error_q && !clr_status);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            tmo_cnt_q          <= '0;
            cmd_valid_q        <= 1'b0;
            cmd_op_q           <= '0;
            cmd_data_q         <= '0;
            cmd_done_q         <= 1'b0;
            cmd_done_err_q     <= 1'b0;
            busy_q             <= 1'b0;
            sticky_overflow_q  <= 1'b0;
            sticky_collision_q <= 1'b0;
            sticky_timeout_q   <= 1'b0;
            sticky_mon_error_q <= 1'b0;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            tmo_cnt_q          <= tmo_cnt_d;
            cmd_valid_q        <= cmd_valid_d;
            cmd_op_q           <= cmd_op_d;
            cmd_data_q         <= cmd_data_d;
            cmd_done_q         <= cmd_done_d;
            cmd_done_err_q     <= cmd_done_err_d;
            busy_q             <= busy_d;
            sticky_overflow_q  <= sticky_overflow_d;
            sticky_collision_q <= sticky_collision_d;
            sticky_timeout_q   <= sticky_timeout_d;
            sticky_mon_error_q <= sticky_mon_error_d;
        end
    end

    assign cmd_valid        = cmd_valid_q;
    assign cmd_op           = cmd_op_q;
    assign cmd_data         = cmd_data_q;
    assign cmd_done         = cmd_done_q;
    assign cmd_done_err     = cmd_done_err_q;
    assign busy             = busy_q;
    assign fifo_level       = count_q;
    assign sticky_overflow  = sticky_overflow_q;
    assign sticky_collision = sticky_collision_q;
    assign sticky_timeout   = sticky_timeout_q;
    assign sticky_mon_error = sticky_mon_error_q;

endmodule

// File: tb/tb_soc1_cpu_debug_action_scheduler.sv
// Randomized bench for the debug action scheduler against a queue-based reference model.
module tb_soc1_cpu_debug_action_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    localparam int S_IDLE  = 0;
    localparam int S_ISSUE = 1;
    localparam int S_WAIT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  strb;
    logic [37:0] jdo;
    logic        cmd_ready, monitor_ready, monitor_error, clr_status;
    logic        cmd_valid, cmd_done, cmd_done_err, busy;
    logic [2:0]  cmd_op;
    logic [37:0] cmd_data;
    logic [2:0]  fifo_level;
    logic        sticky_overflow, sticky_collision, sticky_timeout, sticky_mon_error;

    always #5 clk = ~clk;

    soc1_cpu_debug_action_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .take_action_ocimem_a  (strb[0]),
        .take_action_ocimem_b  (strb[1]),
        .take_action_break_a   (strb[2]),
        .take_action_break_b   (strb[3]),
        .take_action_break_c   (strb[4]),
        .take_action_tracectrl (strb[5]),
        .jdo                   (jdo),
        .cmd_ready             (cmd_ready),
        .monitor_ready         (monitor_ready),
        .monitor_error         (monitor_error),
        .clr_status            (clr_status),
        .cmd_valid             (cmd_valid),
        .cmd_op                (cmd_op),
        .cmd_data              (cmd_data),
        .cmd_done              (cmd_done),
        .cmd_done_err          (cmd_done_err),
        .busy                  (busy),
        .fifo_level            (fifo_level),
        .sticky_overflow       (sticky_overflow),
        .sticky_collision      (sticky_collision),
        .sticky_timeout        (sticky_timeout),
        .sticky_mon_error      (sticky_mon_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending commands in a queue, the one being served, and elapsed wait cycles.
    logic [40:0] m_fifo[$];
    int          m_stage;
    int          m_wait;
    logic        m_valid, m_done, m_err, m_busy;
    logic [2:0]  m_op;
    logic [37:0] m_data;
    logic        m_ovf, m_col, m_tmo, m_merr;

    task automatic model_clear();
        m_fifo.delete();
        m_stage = S_IDLE;
        m_wait  = 0;
        m_valid = 0; m_done = 0; m_err = 0; m_busy = 0;
        m_op = '0; m_data = '0;
        m_ovf = 0; m_col = 0; m_tmo = 0; m_merr = 0;
    endtask

    task automatic model_step();
        logic       hs, s_ovf, s_col, s_tmo, s_merr;
        logic [2:0] win;
        logic [40:0] head;
        if (reset) begin
            model_clear();
            return;
        end
        hs = m_valid && cmd_ready;
        s_ovf = 0; s_col = 0; s_tmo = 0; s_merr = 0;
        m_done = 0; m_err = 0;
        case (m_stage)
            S_IDLE: begin
                m_valid = 0;
                if (m_fifo.size() > 0) begin
                    head   = m_fifo.pop_front();
                    m_op   = head[40:38];
                    m_data = head[37:0];
                    m_stage = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    m_valid = 0;
                    if (m_op < 2) begin
                        m_stage = S_WAIT;
                        m_wait  = 0;
                    end else begin
                        m_stage = S_IDLE;
                        m_done  = 1;
                    end
                end else begin
                    m_valid = 1;
                end
            end
            default: begin
                m_wait++;
                if (monitor_error) begin
                    m_done = 1; m_err = 1; s_merr = 1; m_stage = S_IDLE;
                end else if (monitor_ready) begin
                    m_done = 1; m_stage = S_IDLE;
                end else if (m_wait == TMO) begin
                    m_done = 1; m_err = 1; s_tmo = 1; m_stage = S_IDLE;
                end
            end
        endcase
        if (strb != 0) begin
            win = 3'd0;
            for (int i = 0; i < 6; i++) begin
                if (strb[i]) begin
                    win = 3'(i);
                    break;
                end
            end
            if ($countones(strb) > 1) s_col = 1;
            if (m_fifo.size() < DEPTH) m_fifo.push_back({win, jdo});
            else s_ovf = 1;
        end
        m_ovf  = s_ovf  | (m_ovf  & ~clr_status);
        m_col  = s_col  | (m_col  & ~clr_status);
        m_tmo  = s_tmo  | (m_tmo  & ~clr_status);
        m_merr = s_merr | (m_merr & ~clr_status);
        m_busy = (m_stage != S_IDLE) || (m_fifo.size() > 0);
    endtask

    task automatic compare_all();
        check("cmd_valid",        64'(cmd_valid),        64'(m_valid));
        check("cmd_op",           64'(cmd_op),           64'(m_op));
        check("cmd_data",         64'(cmd_data),         64'(m_data));
        check("cmd_done",         64'(cmd_done),         64'(m_done));
        check("cmd_done_err",     64'(cmd_done_err),     64'(m_err));
        check("busy",             64'(busy),             64'(m_busy));
        check("fifo_level",       64'(fifo_level),       64'(m_fifo.size()));
        check("sticky_overflow",  64'(sticky_overflow),  64'(m_ovf));
        check("sticky_collision", 64'(sticky_collision), 64'(m_col));
        check("sticky_timeout",   64'(sticky_timeout),   64'(m_tmo));
        check("sticky_mon_error", 64'(sticky_mon_error), 64'(m_merr));
    endtask

    // One clock: model tracks the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        strb = '0; clr_status = 0; monitor_ready = 0; monitor_error = 0;
    endtask

    int unsigned p_ready, p_mon, p_strobe;

    initial begin
        reset = 1; jdo = '0; cmd_ready = 0;
        idle_inputs();
        model_clear();
        @(negedge clk);
        cycle();
        cycle();
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        reset = 0;

        // Single break_b command: visible after the second edge, done one cycle after handshake
        strb = 6'b001000; jdo = 38'h2A_DEADBEEF; cmd_ready = 1;
        cycle();
        strb = '0;
        cycle();
        cycle();
        check("t1_valid", 64'(cmd_valid), 64'd1);
        check("t1_op",    64'(cmd_op),    64'd3);
        check("t1_data",  64'(cmd_data),  64'h2A_DEADBEEF);
        cycle();
        check("t1_done",  64'(cmd_done),  64'd1);
        check("t1_err",   64'(cmd_done_err), 64'd0);
        cycle();

        // ocimem_b with no monitor response times out TMO cycles after the handshake
        strb = 6'b000010; jdo = 38'h1_2345_6789;
        cycle();
        strb = '0;
        cycle();
        cycle();
        cycle();
        for (int k = 1; k < int'(TMO); k++) begin
            cycle();
            check("t3_pre_done", 64'(cmd_done), 64'd0);
        end
        cycle();
        check("t3_done", 64'(cmd_done), 64'd1);
        check("t3_err",  64'(cmd_done_err), 64'd1);
        check("t3_sticky", 64'(sticky_timeout), 64'd1);
        clr_status = 1;
        cycle();
        clr_status = 0;
        check("t3_clr", 64'(sticky_timeout), 64'd0);

        // Collision: break_a + tracectrl, break_a wins
        strb = 6'b100100; jdo = 38'h0_0000_00A5;
        cycle();
        strb = '0;
        cycle();
        cycle();
        check("t5_op", 64'(cmd_op), 64'd2);
        check("t5_col", 64'(sticky_collision), 64'd1);

        // Randomized phases with varying backpressure and monitor activity
        for (int blk = 0; blk < 16; blk++) begin
            p_ready  = $urandom_range(0, 100);
            p_mon    = (blk % 3 == 2) ? 0 : $urandom_range(5, 60);
            p_strobe = $urandom_range(10, 70);
            for (int c = 0; c < 200; c++) begin
                reset         = ($urandom_range(0, 299) == 0);
                cmd_ready     = ($urandom_range(0, 99) < p_ready);
                monitor_ready = ($urandom_range(0, 99) < p_mon);
                monitor_error = ($urandom_range(0, 99) < p_mon / 3);
                clr_status    = ($urandom_range(0, 49) == 0);
                jdo           = 38'({$urandom(), $urandom()});
                if ($urandom_range(0, 99) < p_strobe) begin
                    if ($urandom_range(0, 4) == 0) strb = 6'($urandom());
                    else strb = 6'(1 << $urandom_range(0, 5));
                end else begin
                    strb = '0;
                end
                cycle();
            end
        end

        // Reset while waiting on the monitor with entries queued
        reset = 0; idle_inputs(); cmd_ready = 1;
        strb = 6'b000001;
        cycle();
        strb = 6'b010000;
        cycle();
        strb = 6'b100000;
        cycle();
        strb = '0;
        cycle();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        check("t6_valid", 64'(cmd_valid), 64'd0);
        check("t6_level", 64'(fifo_level), 64'd0);
        check("t6_busy",  64'(busy), 64'd0);
        check("t6_done",  64'(cmd_done), 64'd0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
